// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: next-PC select codes,
// fetch FSM states and the default reset PC.
package riscv_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // next_sel encodings; code 3 is reserved and behaves like NEXT_SEQ
   localparam logic [1:0] NEXT_SEQ    = 2'd0;
   localparam logic [1:0] NEXT_PC_IMM = 2'd1;
   localparam logic [1:0] NEXT_JALR   = 2'd2;

   typedef enum logic [1:0] {
      FETCH_REQ   = 2'd0,
      FETCH_WAIT  = 2'd1,
      FETCH_HOLD  = 2'd2,
      FETCH_FAULT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC computation with misalignment detection.
module next_pc_calc
   import riscv_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  next_sel,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   output logic [31:0] target,
   output logic        misaligned
);

   // Select the target source; JALR clears bit 0 so only bit 1 can fault
   always_comb begin
      target = pc + 32'd4;
      case (next_sel)
         NEXT_PC_IMM: target = pc + imm;
         NEXT_JALR:   target = (rs1 + imm) & ~32'h0000_0001;
         default:     target = pc + 32'd4;
      endcase
      misaligned = |target[1:0];
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches words over a
// request/response handshake and hands them to decode until acknowledged.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ack,
   input  logic [1:0]  next_sel,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   output logic        fault
);

   fetch_state_t state_reg;
   logic [31:0]  pc_reg;
   logic [31:0]  instr_reg;
   logic [31:0]  instr_pc_reg;
   logic         instr_valid_reg;
   logic         fault_reg;
   logic [31:0]  target_next;
   logic         misaligned_next;

   next_pc_calc u_next_pc_calc (
      .pc         (pc_reg),
      .next_sel   (next_sel),
      .imm        (imm),
      .rs1        (rs1),
      .target     (target_next),
      .misaligned (misaligned_next)
   );

   // Fetch FSM, PC and instruction registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= FETCH_REQ;
         pc_reg          <= RESET_PC;
         instr_reg       <= 32'h0;
         instr_pc_reg    <= 32'h0;
         instr_valid_reg <= 1'b0;
         fault_reg       <= 1'b0;
      end else begin
         case (state_reg)
            FETCH_REQ: begin
               if (imem_ready) begin
                  state_reg <= FETCH_WAIT;
               end
            end
            FETCH_WAIT: begin
               if (imem_rvalid) begin
                  instr_reg       <= imem_rdata;
                  instr_pc_reg    <= pc_reg;
                  instr_valid_reg <= 1'b1;
                  state_reg       <= FETCH_HOLD;
               end
            end
            FETCH_HOLD: begin
               if (instr_ack) begin
                  instr_valid_reg <= 1'b0;
                  if (misaligned_next) begin
                     fault_reg <= 1'b1;
                     state_reg <= FETCH_FAULT;
                  end else begin
                     pc_reg    <= target_next;
                     state_reg <= FETCH_REQ;
                  end
               end
            end
            default: begin
               // Sticky fault: only reset leaves this state
               instr_valid_reg <= 1'b0;
               fault_reg       <= 1'b1;
            end
         endcase
      end
   end

   // Request must rise in the very first cycle after reset, so it is
   // decoded from the state rather than registered, and masked by rst.
   assign imem_req    = (state_reg == FETCH_REQ) && !rst;
   assign imem_addr   = pc_reg;
   assign instr_valid = instr_valid_reg;
   assign instr       = instr_reg;
   assign instr_pc    = instr_pc_reg;
   assign fault       = fault_reg;

endmodule
